// File: rtl/qea_state_reader.sv
// Readback engine for the QEA state RAM: sweeps every populated word after a run
// and serialises each word into one {real, imag} amplitude per valid/ready beat.
module qea_state_reader #(
  parameter int PE_NUM_WIDTH     = 2,
  parameter int PE_NUM           = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int STATE_DATA_WIDTH = DATA_WIDTH * 2,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH   = 6,
  parameter int RD_LAT           = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]                i_qbit_num,
  output logic [PE_NUM-1:0]                        o_state_ena,
  output logic [PE_NUM-1:0]                        o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]              o_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]       i_state_dout,
  output logic                                     o_amp_valid,
  input  logic                                     i_amp_ready,
  output logic [STATE_DATA_WIDTH-1:0]              o_amp_data,
  output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_amp_index,
  output logic                                     o_amp_last,
  output logic                                     o_busy,
  output logic                                     o_done
);

  localparam int IW  = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int WCW = STATE_ADDR_WIDTH + 1;
  localparam int LW  = 3;
  localparam int DW  = PE_NUM * STATE_DATA_WIDTH;
  localparam logic [MAX_QBIT_WIDTH-1:0] PNW_Q = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] SAW_Q = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH);
  localparam logic [PE_NUM_WIDTH-1:0]   K_MAX = PE_NUM_WIDTH'(PE_NUM - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Number of populated words for a given qubit count, saturated at the RAM depth.
  function automatic logic [WCW-1:0] word_count(input logic [MAX_QBIT_WIDTH-1:0] q);
    logic [WCW-1:0] w;
    logic [MAX_QBIT_WIDTH-1:0] sh;
    sh = q - PNW_Q;
    if (q <= PNW_Q) begin
      w = WCW'(1);
    end else if (sh >= SAW_Q) begin
      w = WCW'(1) << STATE_ADDR_WIDTH;
    end else begin
      w = WCW'(1) << sh;
    end
    return w;
  endfunction

  // Slice 0 is the most significant amplitude of the word.
  function automatic logic [STATE_DATA_WIDTH-1:0] slice(input logic [DW-1:0] word,
                                                         input logic [PE_NUM_WIDTH-1:0] k);
    return word[(PE_NUM - 1 - int'(k)) * STATE_DATA_WIDTH +: STATE_DATA_WIDTH];
  endfunction

  state_t                        state_r, state_n;
  logic [STATE_ADDR_WIDTH-1:0]   addr_r, addr_n;
  logic [WCW-1:0]                words_r, words_n;
  logic [LW-1:0]                 lat_r, lat_n;
  logic [DW-1:0]                 buf_r, buf_n;
  logic [PE_NUM_WIDTH-1:0]       k_r, k_n;
  logic [PE_NUM-1:0]             ena_r, ena_n;
  logic                          valid_r, valid_n;
  logic [STATE_DATA_WIDTH-1:0]   data_r, data_n;
  logic [IW-1:0]                 index_r, index_n;
  logic                          last_r, last_n;
  logic                          busy_r, busy_n;
  logic                          done_r, done_n;
  logic                          is_last_word_s;
  logic [PE_NUM_WIDTH-1:0]       k_inc_s;

  assign is_last_word_s = ({1'b0, addr_r} == (words_r - WCW'(1)));
  assign k_inc_s        = k_r + PE_NUM_WIDTH'(1);

  // Next-state and next-output logic for the readback sequencer.
  always_comb begin
    state_n = state_r;
    addr_n  = addr_r;
    words_n = words_r;
    lat_n   = lat_r;
    buf_n   = buf_r;
    k_n     = k_r;
    ena_n   = {PE_NUM{1'b0}};
    valid_n = valid_r;
    data_n  = data_r;
    index_n = index_r;
    last_n  = last_r;
    busy_n  = busy_r;
    done_n  = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          words_n = word_count(i_qbit_num);
          addr_n  = {STATE_ADDR_WIDTH{1'b0}};
          ena_n   = {PE_NUM{1'b1}};
          busy_n  = 1'b1;
          state_n = REQ;
        end else begin
          state_n = IDLE;
        end
      end
      REQ: begin
        lat_n   = LW'(RD_LAT - 1);
        state_n = WAIT;
      end
      WAIT: begin
        if (lat_r == {LW{1'b0}}) begin
          buf_n   = i_state_dout;
          k_n     = {PE_NUM_WIDTH{1'b0}};
          valid_n = 1'b1;
          data_n  = slice(i_state_dout, {PE_NUM_WIDTH{1'b0}});
          index_n = {addr_r, {PE_NUM_WIDTH{1'b0}}};
          last_n  = is_last_word_s && (PE_NUM == 1);
          state_n = STREAM;
        end else begin
          lat_n = lat_r - LW'(1);
        end
      end
      STREAM: begin
        if (valid_r && i_amp_ready) begin
          if (k_r == K_MAX) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            if (is_last_word_s) begin
              done_n  = 1'b1;
              state_n = DONE;
            end else begin
              addr_n  = addr_r + STATE_ADDR_WIDTH'(1);
              ena_n   = {PE_NUM{1'b1}};
              state_n = REQ;
            end
          end else begin
            k_n     = k_inc_s;
            data_n  = slice(buf_r, k_inc_s);
            index_n = {addr_r, k_inc_s};
            last_n  = is_last_word_s && (k_inc_s == K_MAX);
          end
        end else begin
          state_n = STREAM;
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        valid_n = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any readout without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      addr_r  <= {STATE_ADDR_WIDTH{1'b0}};
      words_r <= {WCW{1'b0}};
      lat_r   <= {LW{1'b0}};
      buf_r   <= {DW{1'b0}};
      k_r     <= {PE_NUM_WIDTH{1'b0}};
      ena_r   <= {PE_NUM{1'b0}};
      valid_r <= 1'b0;
      data_r  <= {STATE_DATA_WIDTH{1'b0}};
      index_r <= {IW{1'b0}};
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      addr_r  <= addr_n;
      words_r <= words_n;
      lat_r   <= lat_n;
      buf_r   <= buf_n;
      k_r     <= k_n;
      ena_r   <= ena_n;
      valid_r <= valid_n;
      data_r  <= data_n;
      index_r <= index_n;
      last_r  <= last_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
    end
  end

  assign o_state_ena   = ena_r;
  assign o_state_wea   = {PE_NUM{1'b0}};
  assign o_state_addra = addr_r;
  assign o_amp_valid   = valid_r;
  assign o_amp_data    = data_r;
  assign o_amp_index   = index_r;
  assign o_amp_last    = last_r;
  assign o_busy        = busy_r;
  assign o_done        = done_r;

endmodule

// File: tb/tb_qea_state_reader.sv
// Randomised bench for qea_state_reader: two instances (RD_LAT 1 and 3) fed by a
// shared RAM model, with beats checked against an index-to-amplitude reference.
module tb_qea_state_reader;

  localparam int WW = 256;
  localparam logic [WW-1:0] JUNK = {8{32'hDEADBEEF}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, sel, ready, mon_clr;
  logic [5:0]  qbits;
  logic        start1, start3;
  assign start1 = start & ~sel;
  assign start3 = start & sel;

  logic [3:0]  ena1, wea1, ena3, wea3;
  logic [15:0] addr1, addr3;
  logic [WW-1:0] dout1, dout3, p0, p1;
  logic        v1, l1, b1, dn1, v3, l3, b3, dn3;
  logic [63:0] d1, d3;
  logic [17:0] i1, i3;

  qea_state_reader #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_qbit_num(qbits),
    .o_state_ena(ena1), .o_state_wea(wea1), .o_state_addra(addr1), .i_state_dout(dout1),
    .o_amp_valid(v1), .i_amp_ready(ready), .o_amp_data(d1), .o_amp_index(i1),
    .o_amp_last(l1), .o_busy(b1), .o_done(dn1));

  qea_state_reader #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(start3), .i_qbit_num(qbits),
    .o_state_ena(ena3), .o_state_wea(wea3), .o_state_addra(addr3), .i_state_dout(dout3),
    .o_amp_valid(v3), .i_amp_ready(ready), .o_amp_data(d3), .o_amp_index(i3),
    .o_amp_last(l3), .o_busy(b3), .o_done(dn3));

  logic [WW-1:0] mem [0:15];

  // RAM models; junk when not enabled so a mistimed capture is visible.
  always @(posedge clk) dout1 <= (ena1 != 4'd0) ? mem[addr1[3:0]] : JUNK;
  always @(posedge clk) begin
    p0    <= (ena3 != 4'd0) ? mem[addr3[3:0]] : JUNK;
    p1    <= p0;
    dout3 <= p1;
  end

  logic [3:0]  oena, owea;
  logic [15:0] oaddr;
  logic        ov, ol, obusy, odone;
  logic [63:0] od;
  logic [17:0] oi;
  assign oena  = sel ? ena3  : ena1;
  assign owea  = sel ? wea3  : wea1;
  assign oaddr = sel ? addr3 : addr1;
  assign ov    = sel ? v3    : v1;
  assign od    = sel ? d3    : d1;
  assign oi    = sel ? i3    : i1;
  assign ol    = sel ? l3    : l1;
  assign obusy = sel ? b3    : b1;
  assign odone = sel ? dn3   : dn1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  int start_cyc, first_valid, done_rel, done_cnt, stall_err, order_err;
  logic [63:0] bq_data[$];
  logic [17:0] bq_idx[$];
  logic        bq_last[$];
  logic [15:0] eq_addr[$];
  int          eq_cyc[$];
  logic        pv, pr, pl;
  logic [63:0] pd;
  logic [17:0] pi;

  // Monitor: records completed beats, RAM requests and done pulses mid-cycle.
  always @(negedge clk) begin
    #1;
    if (mon_clr) begin
      bq_data.delete(); bq_idx.delete(); bq_last.delete();
      eq_addr.delete(); eq_cyc.delete();
      first_valid = -1; done_rel = -1; done_cnt = 0; stall_err = 0; order_err = 0;
      start_cyc = cyc;
    end
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && (!ov || od !== pd || oi !== pi || ol !== pl)) stall_err++;
      if (ov && first_valid < 0) first_valid = cyc - start_cyc;
      if (ov && ready) begin
        bq_data.push_back(od); bq_idx.push_back(oi); bq_last.push_back(ol);
      end
      if (oena != 4'd0) begin
        if (oena != 4'hF || ov || bq_data.size() != 4 * eq_addr.size()) order_err++;
        eq_addr.push_back(oaddr); eq_cyc.push_back(cyc - start_cyc);
      end
      if (owea != 4'd0) order_err++;
      if (odone) begin
        done_cnt++; done_rel = cyc - start_cyc;
      end
      pv = ov; pr = ready; pd = od; pi = oi; pl = ol;
    end
  end

  // Reference: amplitude i lives in word i/PE_NUM, slice 0 at the top of the word.
  function automatic logic [63:0] exp_amp(input int i);
    logic [WW-1:0] w;
    w = mem[i / 4] >> ((3 - (i % 4)) * 64);
    return w[63:0];
  endfunction

  function automatic int words_for(input int q);
    return (q <= 2) ? 1 : (1 << (q - 2));
  endfunction

  task automatic fill_random();
    for (int w = 0; w < 16; w++)
      for (int j = 0; j < 8; j++) mem[w][j*32 +: 32] = $urandom();
  endtask

  task automatic run(input logic [5:0] q, input int mode, input bit extra, output bit timeout);
    bit fired;
    fired = 1'b0;
    @(negedge clk);
    qbits = q; start = 1'b1; mon_clr = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0; mon_clr = 1'b0;
    timeout = 1'b1;
    for (int c = 0; c < 400; c++) begin
      ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~c[0] : 1'($urandom_range(0, 1));
      start = 1'b0;
      if (extra && ov && oi == 18'd5 && !fired) begin
        start = 1'b1; fired = 1'b1;
      end
      if (odone) begin
        if (extra) start = 1'b1;
        timeout = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({v1, d1, i1, l1, ena1, addr1, b1, dn1} !== '0) begin
      n_err++; $display("FAIL reset_dut1 got %h want 0", {v1, d1, i1, l1, ena1, addr1, b1, dn1});
    end
    n_vec++;
    if ({v3, d3, i3, l3, ena3, addr3, b3, dn3} !== '0) begin
      n_err++; $display("FAIL reset_dut3 got %h want 0", {v3, d3, i3, l3, ena3, addr3, b3, dn3});
    end
  endtask

  task automatic test_base();
    bit to;
    sel = 1'b0;
    for (int w = 0; w < 16; w++) mem[w] = '0;
    mem[0] = {64'h40000000_00000000, 192'd0};
    run(6'd4, 0, 1'b0, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL base_timeout got %0b want 0", to); end
    n_vec++; if (bq_data.size() != 16) begin n_err++; $display("FAIL base_count got %0d want 16", bq_data.size()); end
    for (int i = 0; i < bq_data.size() && i < 16; i++) begin
      n_vec++;
      if (bq_data[i] !== exp_amp(i) || bq_idx[i] !== 18'(i) || bq_last[i] !== (i == 15)) begin
        n_err++; $display("FAIL base_beat%0d got %h/%0d/%0b want %h/%0d/%0b",
                          i, bq_data[i], bq_idx[i], bq_last[i], exp_amp(i), i, i == 15);
      end
    end
    n_vec++; if (eq_addr.size() != 4) begin n_err++; $display("FAIL base_req_count got %0d want 4", eq_addr.size()); end
    for (int j = 0; j < eq_addr.size() && j < 4; j++) begin
      n_vec++;
      if (eq_addr[j] !== 16'(j) || eq_cyc[j] != 1 + 6 * j) begin
        n_err++; $display("FAIL base_req%0d got addr %0d cyc %0d want addr %0d cyc %0d",
                          j, eq_addr[j], eq_cyc[j], j, 1 + 6 * j);
      end
    end
    n_vec++; if (first_valid != 3) begin n_err++; $display("FAIL base_first_valid got %0d want 3", first_valid); end
    n_vec++; if (done_rel != 25 || done_cnt != 1) begin
      n_err++; $display("FAIL base_done got cyc %0d cnt %0d want cyc 25 cnt 1", done_rel, done_cnt);
    end
    n_vec++; if (order_err != 0) begin n_err++; $display("FAIL base_req_order got %0d want 0", order_err); end
  endtask

  task automatic test_backpressure();
    bit to;
    sel = 1'b0;
    for (int mode = 1; mode <= 2; mode++) begin
      fill_random();
      run(6'd4, mode, 1'b0, to);
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL bp%0d_timeout got %0b want 0", mode, to); end
      n_vec++; if (bq_data.size() != 16) begin n_err++; $display("FAIL bp%0d_count got %0d want 16", mode, bq_data.size()); end
      for (int i = 0; i < bq_data.size() && i < 16; i++) begin
        n_vec++;
        if (bq_data[i] !== exp_amp(i) || bq_idx[i] !== 18'(i) || bq_last[i] !== (i == 15)) begin
          n_err++; $display("FAIL bp%0d_beat%0d got %h/%0d want %h/%0d", mode, i, bq_data[i], bq_idx[i], exp_amp(i), i);
        end
      end
      n_vec++; if (stall_err != 0) begin n_err++; $display("FAIL bp%0d_stall_stable got %0d want 0", mode, stall_err); end
      n_vec++; if (order_err != 0 || eq_addr.size() != 4) begin
        n_err++; $display("FAIL bp%0d_req_order got err %0d reqs %0d want 0/4", mode, order_err, eq_addr.size());
      end
    end
  endtask

  task automatic test_small();
    bit to;
    sel = 1'b0;
    fill_random();
    for (int q = 2; q >= 1; q--) begin
      run(6'(q), 0, 1'b0, to);
      n_vec++; if (to !== 1'b0 || bq_data.size() != 4 * words_for(q)) begin
        n_err++; $display("FAIL small%0d_count got %0d timeout %0b want 4", q, bq_data.size(), to);
      end
      for (int i = 0; i < bq_data.size() && i < 4; i++) begin
        n_vec++;
        if (bq_data[i] !== exp_amp(i) || bq_idx[i] !== 18'(i) || bq_last[i] !== (i == 3)) begin
          n_err++; $display("FAIL small%0d_beat%0d got %h/%0d/%0b want %h/%0d/%0b",
                            q, i, bq_data[i], bq_idx[i], bq_last[i], exp_amp(i), i, i == 3);
        end
      end
      n_vec++; if (eq_addr.size() != 1 || eq_addr[0] !== 16'd0) begin
        n_err++; $display("FAIL small%0d_req got %0d reqs want 1 at addr 0", q, eq_addr.size());
      end
    end
  endtask

  task automatic test_start_filter();
    bit to;
    sel = 1'b0;
    fill_random();
    run(6'd4, 2, 1'b1, to);
    n_vec++; if (to !== 1'b0 || bq_data.size() != 16 || done_cnt != 1) begin
      n_err++; $display("FAIL filter_counts got beats %0d done %0d want 16/1", bq_data.size(), done_cnt);
    end
    n_vec++; if (eq_addr.size() != 4) begin n_err++; $display("FAIL filter_reqs got %0d want 4", eq_addr.size()); end
    run(6'd4, 0, 1'b0, to);
    n_vec++; if (to !== 1'b0 || eq_addr.size() == 0 || eq_addr[0] !== 16'd0 || bq_data.size() != 16) begin
      n_err++; $display("FAIL filter_restart got reqs %0d beats %0d want restart from 0", eq_addr.size(), bq_data.size());
    end
    for (int i = 0; i < bq_data.size() && i < 16; i++) begin
      n_vec++;
      if (bq_data[i] !== exp_amp(i) || bq_idx[i] !== 18'(i)) begin
        n_err++; $display("FAIL filter_beat%0d got %h/%0d want %h/%0d", i, bq_data[i], bq_idx[i], exp_amp(i), i);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit, to;
    sel = 1'b0; hit = 1'b0;
    fill_random();
    @(negedge clk);
    qbits = 6'd4; start = 1'b1; mon_clr = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0; mon_clr = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (ov && oi == 18'd6) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL rstmid_reach got %0b want 1", hit); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ov, od, oi, ol, oena, oaddr, obusy, odone} !== '0) begin
      n_err++; $display("FAIL rstmid_async got %h want 0", {ov, od, oi, ol, oena, oaddr, obusy, odone});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++; if (done_cnt != 0 || obusy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_no_done got done %0d busy %0b want 0/0", done_cnt, obusy);
    end
    run(6'd4, 0, 1'b0, to);
    n_vec++; if (to !== 1'b0 || bq_data.size() != 16 || done_cnt != 1) begin
      n_err++; $display("FAIL rstmid_rerun got beats %0d done %0d want 16/1", bq_data.size(), done_cnt);
    end
    for (int i = 0; i < bq_data.size() && i < 16; i++) begin
      n_vec++;
      if (bq_data[i] !== exp_amp(i) || bq_idx[i] !== 18'(i)) begin
        n_err++; $display("FAIL rstmid_beat%0d got %h/%0d want %h/%0d", i, bq_data[i], bq_idx[i], exp_amp(i), i);
      end
    end
  endtask

  task automatic test_latency();
    bit to;
    sel = 1'b1;
    fill_random();
    run(6'd4, 0, 1'b0, to);
    n_vec++; if (to !== 1'b0 || bq_data.size() != 16) begin
      n_err++; $display("FAIL lat_count got %0d timeout %0b want 16", bq_data.size(), to);
    end
    for (int i = 0; i < bq_data.size() && i < 16; i++) begin
      n_vec++;
      if (bq_data[i] !== exp_amp(i) || bq_idx[i] !== 18'(i) || bq_last[i] !== (i == 15)) begin
        n_err++; $display("FAIL lat_beat%0d got %h/%0d want %h/%0d", i, bq_data[i], bq_idx[i], exp_amp(i), i);
      end
    end
    n_vec++; if (first_valid != 5) begin n_err++; $display("FAIL lat_first_valid got %0d want 5", first_valid); end
    for (int j = 0; j < eq_cyc.size() && j < 4; j++) begin
      n_vec++;
      if (eq_cyc[j] != 1 + 8 * j || eq_addr[j] !== 16'(j)) begin
        n_err++; $display("FAIL lat_req%0d got cyc %0d addr %0d want cyc %0d addr %0d", j, eq_cyc[j], eq_addr[j], 1 + 8 * j, j);
      end
    end
    n_vec++; if (done_rel != 33) begin n_err++; $display("FAIL lat_done got %0d want 33", done_rel); end
    sel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; ready = 1'b0; qbits = 6'd0; mon_clr = 1'b0;
    for (int w = 0; w < 16; w++) mem[w] = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_base();
    test_backpressure();
    test_small();
    test_start_filter();
    test_reset_mid();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qea_state_reader.md
Name: qea_state_reader

Overview:
- Readback engine for the QEA state RAM. It runs after o_complete.
- Sweeps the state RAM port A through every populated word and captures each PE_NUM-wide word.
- Serialises each word into one complex amplitude per beat on a valid/ready stream with a global amplitude index.
- Sits between the QEA i_state_* read port / o_state_dout and the host-side result sink or DMA. It is the read-direction counterpart of the state preload sequence.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE_NUM.
- PE_NUM, 4, number of amplitude slices per state RAM word.
- DATA_WIDTH, 32, width of one real or imaginary component (fixed point, 30 fractional bits; passed through untouched).
- STATE_DATA_WIDTH, DATA_WIDTH*2, one amplitude: {real, imag}, real in the upper half.
- STATE_ADDR_WIDTH, 16, state RAM word address width.
- MAX_QBIT_WIDTH, 6, width of the qubit-count input.
- RD_LAT, 1, state RAM read latency in cycles from the enable cycle to valid o_state_dout (legal range 1..4).

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- i_start, input, 1, single-cycle pulse that starts a readout; sampled only in IDLE.
- i_qbit_num, input, MAX_QBIT_WIDTH, qubit count; sampled on an accepted i_start.
- o_state_ena, output, PE_NUM, state RAM enable; all ones during the request cycle, else 0.
- o_state_wea, output, PE_NUM, state RAM write enable; constant 0.
- o_state_addra, output, STATE_ADDR_WIDTH, state RAM word address.
- i_state_dout, input, PE_NUM*STATE_DATA_WIDTH, state RAM read data.
- o_amp_valid, output, 1, amplitude beat valid.
- i_amp_ready, input, 1, sink ready.
- o_amp_data, output, STATE_DATA_WIDTH, amplitude {real, imag}.
- o_amp_index, output, STATE_ADDR_WIDTH+PE_NUM_WIDTH, global amplitude index.
- o_amp_last, output, 1, marks the final amplitude of the readout.
- o_busy, output, 1, high from the accepted start until the DONE state exits.
- o_done, output, 1, one-cycle pulse after the last beat completes.

Behaviour:
- Reset (async, rst_n=0): all registers clear immediately. All outputs are 0, including o_amp_data, o_amp_index and o_state_addra. The FSM goes to IDLE. An in-flight readout is abandoned with no o_done.
- Word count W = 2^(i_qbit_num - PE_NUM_WIDTH).
  - If i_qbit_num <= PE_NUM_WIDTH, W = 1.
  - If i_qbit_num - PE_NUM_WIDTH >= STATE_ADDR_WIDTH, W = 2^STATE_ADDR_WIDTH.
  - The word counter is STATE_ADDR_WIDTH+1 bits wide so the maximum W does not overflow.
- Slice order within a word: slice k=0 is the most significant STATE_DATA_WIDTH field of i_state_dout, and k=PE_NUM-1 is the least significant.
- o_amp_index = {word_addr, k}, i.e. word_addr*PE_NUM + k.
- FSM states: IDLE, REQ, WAIT, STREAM, DONE.
  - IDLE: on i_start=1, latch W, set the address to 0, go to REQ. i_start in any other state is ignored.
  - REQ (1 cycle): drive o_state_ena all ones and o_state_addra = current address, then go to WAIT.
  - WAIT (RD_LAT cycles, down-counter): on its final cycle, register i_state_dout into a capture buffer, set k=0, go to STREAM.
  - STREAM: present o_amp_valid=1 with the data and index of slice k.
    - A beat completes on valid & ready; then increment k.
    - After the beat with k=PE_NUM-1: if this is the last word, go to DONE; otherwise increment the address and go to REQ.
  - DONE (1 cycle): o_done=1, o_busy=1, then go to IDLE with o_busy=0.
- Handshake rules:
  - o_amp_valid never depends combinationally on i_amp_ready.
  - Once valid is asserted, data, index and last hold stable until the beat completes.
  - There is no cap on stall length.
- o_amp_last=1 only on the beat with index W*PE_NUM-1.
- o_state_addra holds its value outside REQ. o_state_ena is 0 in every state except REQ.
- Timing with i_amp_ready held at 1 and i_start accepted at edge 0:
  - REQ occupies cycle 1.
  - The first valid beat appears at cycle 2+RD_LAT.
  - Each word costs 1+RD_LAT+PE_NUM cycles.
  - o_done occurs on the cycle after the last beat.
- The capture buffer holds one word; there is no prefetch.

Test Plan:
- Base readout, no stall: RD_LAT=1, RAM model word0 = {0x40000000_00000000, 0, 0, 0}, words 1..3 zero, i_qbit_num=4, i_amp_ready=1.
  - Exactly 16 beats with indices 0..15.
  - Beat 0 data 0x40000000_00000000, all other beats 0.
  - o_amp_last only at index 15.
  - o_state_ena pulses 4 times at addresses 0..3.
  - First valid at cycle 3, o_done at cycle 25.
- Backpressure: distinct data in every slice, i_amp_ready patterns 1010... and a random pattern.
  - Data and index stable while valid & !ready.
  - The 16 beats arrive in order with no loss or duplication.
  - No RAM request is issued until the previous word has fully drained.
- Small circuits: i_qbit_num=2 and i_qbit_num=1.
  - One word, 4 beats, indices 0..3, o_amp_last on index 3, one o_state_ena pulse at address 0.
- Start filtering: i_start pulsed again mid-STREAM and during DONE.
  - Both pulses are ignored; the beat count is still 16 and there is a single o_done.
  - A new i_start in IDLE restarts from address 0.
- Reset mid-operation: rst_n=0 asynchronously during beat 6.
  - All outputs go to 0 without a clock edge, and no o_done is produced.
  - After release, i_start gives a full 16-beat readout from index 0.
- Latency parameter: RD_LAT=3 with the RAM model delayed to match.
  - Captured data is correct for every word.
  - First valid at cycle 5; per-word period is 8 cycles with ready=1.
